// File: rtl/prv664_pkg.sv
// Shared prv664 types for the FP scoreboard issue path: issue FSM states,
// the buffered per-slot instruction fields, and a source-index helper.
package prv664_pkg;

  // Widest itag any instance may use; narrower instances zero-extend into it.
  localparam int unsigned ITAG_MAX = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLOT0 = 2'd1,
    SLOT1 = 2'd2
  } fsb_state_e;

  typedef struct packed {
    logic [14:0]         rs;    // {rs3, rs2, rs1}
    logic [2:0]          rsen;  // per-source read enables
    logic                rdwr;  // slot writes an FP register
    logic [4:0]          rd;
    logic [ITAG_MAX-1:0] itag;
  } fp_issue_slot_t;

  // Extract source register n (0 = rs1) from the packed source field.
  function automatic logic [4:0] rs_idx(input logic [14:0] rs, input int unsigned n);
    return rs[5*n +: 5];
  endfunction

endpackage

// File: rtl/prv664_fsb_hazard_chk.sv
// RAW hazard check for one issue slot against the FP scoreboard busy vector,
// with a same-cycle bypass for the register being committed right now.
module prv664_fsb_hazard_chk
  import prv664_pkg::*;
(
  input  logic [14:0] rs_i,
  input  logic [2:0]  rsen_i,
  input  logic [31:0] busy_flag_i,
  input  logic        commit0_valid_i,
  input  logic        commit0_wren_i,
  input  logic [4:0]  commit0_rdindex_i,
  output logic        hazard_o
);

  logic commit_clr;
  assign commit_clr = commit0_valid_i & commit0_wren_i;

  // Any enabled source still busy and not being released this cycle stalls the slot.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hazard_o = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (rsen_i[i] && busy_flag_i[rs_idx(rs_i, i)] &&
          !(commit_clr && (commit0_rdindex_i == rs_idx(rs_i, i)))) begin
        hazard_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prv664_fsb_issue_ctrl.sv
// FP pair issue controller: buffers one incoming FP instruction pair, issues
// the slots in order once their sources are free, and posts each issuing
// slot's destination to the FP scoreboard in the cycle it fires.
module prv664_fsb_issue_ctrl
  import prv664_pkg::*;
#(
  parameter int unsigned IDLEN = 8  // must not exceed ITAG_MAX
) (
  input  logic             clk_i,
  input  logic             srstn_i,
  input  logic             flush_i,
  input  logic [1:0]       req_valid_i,
  output logic             req_ready_o,
  input  logic [14:0]      req0_rs_i,
  input  logic [2:0]       req0_rsen_i,
  input  logic             req0_rdwr_i,
  input  logic [4:0]       req0_rd_i,
  input  logic [IDLEN-1:0] req0_itag_i,
  input  logic [14:0]      req1_rs_i,
  input  logic [2:0]       req1_rsen_i,
  input  logic             req1_rdwr_i,
  input  logic [4:0]       req1_rd_i,
  input  logic [IDLEN-1:0] req1_itag_i,
  input  logic [31:0]      busy_flag_i,
  input  logic             commit0_valid_i,
  input  logic             commit0_wren_i,
  input  logic [4:0]       commit0_rdindex_i,
  output logic             fsb_write_o,
  output logic [4:0]       fsb_rdindex_o,
  output logic [IDLEN-1:0] fsb_itag_o,
  output logic             iss_valid_o,
  input  logic             iss_ready_i,
  output logic             iss_slot_o,
  output logic [IDLEN-1:0] iss_itag_o
);

  fsb_state_e     state_q, state_d;
  fp_issue_slot_t slot_q [2];
  logic [1:0]     valid_q;

  fp_issue_slot_t cur_slot;
  logic           hazard;
  logic           run;
  logic           fire;
  logic           last_fire;
  logic           accept;
  logic           itag_hi_unused;

  // The slot under evaluation is selected purely by the FSM state.
  assign cur_slot = (state_q == SLOT1) ? slot_q[1] : slot_q[0];

  prv664_fsb_hazard_chk u_hazard_chk (
    .rs_i              (cur_slot.rs),
    .rsen_i            (cur_slot.rsen),
    .busy_flag_i       (busy_flag_i),
    .commit0_valid_i   (commit0_valid_i),
    .commit0_wren_i    (commit0_wren_i),
    .commit0_rdindex_i (commit0_rdindex_i),
    .hazard_o          (hazard)
  );

  assign fsb_rdindex_o  = cur_slot.rd;
  assign fsb_itag_o     = cur_slot.itag[IDLEN-1:0];
  assign iss_slot_o     = (state_q == SLOT1);
  assign iss_itag_o     = cur_slot.itag[IDLEN-1:0];
  // Upper itag bits beyond IDLEN are always zero.
  assign itag_hi_unused = ^cur_slot.itag;

  // Issue handshake, scoreboard update and next-state selection.
  always_comb begin
    state_d     = state_q;
    run         = srstn_i & ~flush_i;
    iss_valid_o = run && (state_q != IDLE) && !hazard;
    fire        = iss_valid_o & iss_ready_i;
    fsb_write_o = fire & cur_slot.rdwr;
    // The slot firing now is the last one buffered: the buffer frees at this edge.
    last_fire   = fire && ((state_q == SLOT1) || !valid_q[1]);
    req_ready_o = run && ((state_q == IDLE) || last_fire);
    accept      = req_ready_o & (|req_valid_i);

    unique case (state_q)
      IDLE:    state_d = IDLE;
      SLOT0:   if (fire) state_d = valid_q[1] ? SLOT1 : IDLE;
      SLOT1:   if (fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) state_d = req_valid_i[0] ? SLOT0 : SLOT1;
    if (!run)   state_d = IDLE;
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!srstn_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Per-slot valid bits: set on acceptance, cleared on flush or once drained.
  always_ff @(posedge clk_i) begin
    if (!srstn_i || flush_i) valid_q <= 2'b00;
    else if (accept)         valid_q <= req_valid_i;
    else if (last_fire)      valid_q <= 2'b00;
  end

  // Pair payload, captured on acceptance.
  // NOTE: the payload is deliberately not reset; it is only read while its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      slot_q[0] <= '{rs: req0_rs_i, rsen: req0_rsen_i, rdwr: req0_rdwr_i,
                     rd: req0_rd_i, itag: ITAG_MAX'(req0_itag_i)};
      slot_q[1] <= '{rs: req1_rs_i, rsen: req1_rsen_i, rdwr: req1_rdwr_i,
                     rd: req1_rd_i, itag: ITAG_MAX'(req1_itag_i)};
    end
  end

endmodule

// File: tb/tb_prv664_fsb_issue_ctrl.sv
// Self-checking bench for prv664_fsb_issue_ctrl: a queue-of-pending-slots
// model plus a tiny FP scoreboard drive the per-cycle comparison, and
// directed scenarios pin key cycles with literal expectations.
module tb_prv664_fsb_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        srstn_i, flush_i;
  logic [1:0]  req_valid_i;
  logic        req_ready_o;
  logic [14:0] req0_rs_i, req1_rs_i;
  logic [2:0]  req0_rsen_i, req1_rsen_i;
  logic        req0_rdwr_i, req1_rdwr_i;
  logic [4:0]  req0_rd_i, req1_rd_i;
  logic [7:0]  req0_itag_i, req1_itag_i;
  logic [31:0] busy_flag_i;
  logic        commit0_valid_i, commit0_wren_i;
  logic [4:0]  commit0_rdindex_i;
  logic        fsb_write_o;
  logic [4:0]  fsb_rdindex_o;
  logic [7:0]  fsb_itag_o;
  logic        iss_valid_o, iss_ready_i, iss_slot_o;
  logic [7:0]  iss_itag_o;

  prv664_fsb_issue_ctrl #(.IDLEN(8)) dut (
    .clk_i(clk_i), .srstn_i(srstn_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req0_rs_i(req0_rs_i), .req0_rsen_i(req0_rsen_i), .req0_rdwr_i(req0_rdwr_i),
    .req0_rd_i(req0_rd_i), .req0_itag_i(req0_itag_i),
    .req1_rs_i(req1_rs_i), .req1_rsen_i(req1_rsen_i), .req1_rdwr_i(req1_rdwr_i),
    .req1_rd_i(req1_rd_i), .req1_itag_i(req1_itag_i),
    .busy_flag_i(busy_flag_i),
    .commit0_valid_i(commit0_valid_i), .commit0_wren_i(commit0_wren_i),
    .commit0_rdindex_i(commit0_rdindex_i),
    .fsb_write_o(fsb_write_o), .fsb_rdindex_o(fsb_rdindex_o), .fsb_itag_o(fsb_itag_o),
    .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
    .iss_slot_o(iss_slot_o), .iss_itag_o(iss_itag_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        slot;
    logic [14:0] rs;
    logic [2:0]  rsen;
    logic        rdwr;
    logic [4:0]  rd;
    logic [7:0]  itag;
  } ent_t;

  typedef struct packed {
    logic iss_valid;
    logic fire;
    logic write;
    logic ready;
  } exp_t;

  ent_t        q[$];            // slots still waiting to issue, oldest first
  logic [31:0] sb_busy  = '0;   // model scoreboard, set by updates, cleared by commits
  logic [31:0] man_busy = '0;   // busy bits forced directly by the stimulus
  assign busy_flag_i = sb_busy | man_busy;

  function automatic logic src_busy(input ent_t e);
    logic b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [4:0] idx = e.rs[5*i +: 5];
      if (e.rsen[i] && busy_flag_i[idx] &&
          !(commit0_valid_i && commit0_wren_i && commit0_rdindex_i == idx)) b = 1'b1;
    end
    return b;
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    e.iss_valid = srstn_i && !flush_i && (q.size() > 0) && !src_busy(q[0]);
    e.fire      = e.iss_valid && iss_ready_i;
    e.write     = e.fire && q[0].rdwr;
    e.ready     = srstn_i && !flush_i && (q.size() == 0 || (q.size() == 1 && e.fire));
    return e;
  endfunction

  // Advance the model at each rising edge from the inputs of the ending cycle.
  always @(posedge clk_i) begin : model_upd
    exp_t        e;
    logic [31:0] sb_n;
    e    = model_exp();
    sb_n = sb_busy;
    if (!srstn_i) begin
      q.delete();
      sb_n = '0;
    end else if (flush_i) begin
      q.delete();
    end else begin
      if (commit0_valid_i && commit0_wren_i) sb_n[commit0_rdindex_i] = 1'b0;
      if (e.write) sb_n[q[0].rd] = 1'b1;
      if (e.fire) void'(q.pop_front());
      if (e.ready && req_valid_i[0])
        q.push_back('{slot: 1'b0, rs: req0_rs_i, rsen: req0_rsen_i, rdwr: req0_rdwr_i,
                      rd: req0_rd_i, itag: req0_itag_i});
      if (e.ready && req_valid_i[1])
        q.push_back('{slot: 1'b1, rs: req1_rs_i, rsen: req1_rsen_i, rdwr: req1_rdwr_i,
                      rd: req1_rd_i, itag: req1_itag_i});
    end
    sb_busy <= sb_n;
  end

  // Compare every cycle, mid-period, against the model.
  always @(negedge clk_i) begin : compare
    exp_t e;
    e = model_exp();
    check("req_ready", req_ready_o, e.ready);
    check("iss_valid", iss_valid_o, e.iss_valid);
    check("fsb_write", fsb_write_o, e.write);
    if (e.iss_valid) begin
      check("iss_slot", iss_slot_o, q[0].slot);
      check("iss_itag", iss_itag_o, q[0].itag);
    end
    if (e.write) begin
      check("fsb_rdindex", fsb_rdindex_o, q[0].rd);
      check("fsb_itag", fsb_itag_o, q[0].itag);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  task automatic set_pair(input logic [1:0] v,
                          input logic [14:0] rs0, input logic [2:0] en0, input logic wr0,
                          input logic [4:0] rd0, input logic [7:0] tag0,
                          input logic [14:0] rs1, input logic [2:0] en1, input logic wr1,
                          input logic [4:0] rd1, input logic [7:0] tag1);
    req_valid_i = v;
    req0_rs_i = rs0; req0_rsen_i = en0; req0_rdwr_i = wr0; req0_rd_i = rd0; req0_itag_i = tag0;
    req1_rs_i = rs1; req1_rsen_i = en1; req1_rdwr_i = wr1; req1_rd_i = rd1; req1_itag_i = tag1;
  endtask

  task automatic commit(input logic v, input logic [4:0] idx);
    commit0_valid_i = v; commit0_wren_i = v; commit0_rdindex_i = idx;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin : stim
    srstn_i = 1'b0; flush_i = 1'b0; iss_ready_i = 1'b1;
    set_pair(2'b00, '0, '0, 1'b0, '0, '0, '0, '0, 1'b0, '0, '0);
    commit(1'b0, 5'd0);

    // Reset state
    mid();
    check("rst_req_ready", req_ready_o, 1'b0);
    check("rst_iss_valid", iss_valid_o, 1'b0);
    check("rst_fsb_write", fsb_write_o, 1'b0);
    tick(); tick();
    srstn_i = 1'b1;
    mid(); check("idle_ready", req_ready_o, 1'b1);

    // Both slots free: slot0 fires at N+1, slot1 at N+2
    tick(); set_pair(2'b11, '0, 3'b000, 1'b1, 5'd7, 8'h21, '0, 3'b000, 1'b1, 5'd9, 8'h22);
    tick(); req_valid_i = 2'b00;
    mid();
    check("t1_s0_write", fsb_write_o, 1'b1);
    check("t1_s0_rd", fsb_rdindex_o, 5'd7);
    check("t1_s0_itag", fsb_itag_o, 8'h21);
    check("t1_s0_slot", iss_slot_o, 1'b0);
    tick(); mid();
    check("t1_s1_write", fsb_write_o, 1'b1);
    check("t1_s1_rd", fsb_rdindex_o, 5'd9);
    check("t1_s1_itag", fsb_itag_o, 8'h22);
    check("t1_s1_slot", iss_slot_o, 1'b1);
    check("t1_s1_ready", req_ready_o, 1'b1);
    tick(); mid(); check("t1_idle", iss_valid_o, 1'b0);

    // Busy source released by same-cycle commit bypass
    tick(); man_busy[5] = 1'b1;
    set_pair(2'b01, 15'd5, 3'b001, 1'b0, 5'd2, 8'h30, '0, 3'b000, 1'b0, '0, '0);
    tick(); req_valid_i = 2'b00;
    mid(); check("t2_stall_a", iss_valid_o, 1'b0);
    tick(); tick(); mid(); check("t2_stall_b", iss_valid_o, 1'b0);
    tick(); commit(1'b1, 5'd5);
    mid();
    check("t2_bypass", iss_valid_o, 1'b1);
    check("t2_no_write", fsb_write_o, 1'b0);
    check("t2_itag", iss_itag_o, 8'h30);
    tick(); commit(1'b0, 5'd0); man_busy[5] = 1'b0;
    mid(); check("t2_done", iss_valid_o, 1'b0);

    // Intra-pair RAW through the model scoreboard
    tick(); set_pair(2'b11, '0, 3'b000, 1'b1, 5'd3, 8'h10,
                     {5'd0, 5'd3, 5'd0}, 3'b010, 1'b1, 5'd4, 8'h11);
    tick(); req_valid_i = 2'b00;
    mid(); check("t3_s0_write", fsb_write_o, 1'b1); check("t3_s0_rd", fsb_rdindex_o, 5'd3);
    tick(); mid(); check("t3_raw_stall_a", iss_valid_o, 1'b0);
    tick(); tick(); mid(); check("t3_raw_stall_b", iss_valid_o, 1'b0);
    tick(); commit(1'b1, 5'd3);
    mid();
    check("t3_s1_write", fsb_write_o, 1'b1);
    check("t3_s1_rd", fsb_rdindex_o, 5'd4);
    check("t3_s1_itag", fsb_itag_o, 8'h11);
    tick(); commit(1'b0, 5'd0);
    mid(); check("t3_ready", req_ready_o, 1'b1);

    // Only slot1 valid: direct entry into SLOT1, one update
    tick(); set_pair(2'b10, '0, 3'b000, 1'b1, 5'd1, 8'h55, '0, 3'b000, 1'b1, 5'd11, 8'h33);
    tick(); req_valid_i = 2'b00;
    mid();
    check("t4_slot", iss_slot_o, 1'b1);
    check("t4_write", fsb_write_o, 1'b1);
    check("t4_rd", fsb_rdindex_o, 5'd11);
    check("t4_itag", fsb_itag_o, 8'h33);
    tick(); mid();
    check("t4_single", fsb_write_o, 1'b0);
    check("t4_ready", req_ready_o, 1'b1);

    // Flush while in SLOT1, with a new pair offered that cycle
    tick(); set_pair(2'b11, '0, 3'b000, 1'b1, 5'd12, 8'h40, '0, 3'b000, 1'b1, 5'd13, 8'h41);
    tick(); req_valid_i = 2'b00;
    mid(); check("t5_s0_rd", fsb_rdindex_o, 5'd12);
    tick(); flush_i = 1'b1;
    set_pair(2'b11, '0, 3'b000, 1'b1, 5'd14, 8'h50, '0, 3'b000, 1'b1, 5'd15, 8'h51);
    mid();
    check("t5_fl_write", fsb_write_o, 1'b0);
    check("t5_fl_ready", req_ready_o, 1'b0);
    check("t5_fl_valid", iss_valid_o, 1'b0);
    tick(); flush_i = 1'b0; req_valid_i = 2'b00;
    mid();
    check("t5_idle_ready", req_ready_o, 1'b1);
    check("t5_idle_valid", iss_valid_o, 1'b0);

    // Reset while held in SLOT0
    tick(); man_busy[20] = 1'b1;
    set_pair(2'b01, 15'd20, 3'b001, 1'b1, 5'd6, 8'h60, '0, 3'b000, 1'b0, '0, '0);
    tick(); req_valid_i = 2'b00;
    mid(); check("t6_hold", iss_valid_o, 1'b0);
    tick(); srstn_i = 1'b0; man_busy[20] = 1'b0;
    mid();
    check("t6_rst_ready", req_ready_o, 1'b0);
    check("t6_rst_valid", iss_valid_o, 1'b0);
    check("t6_rst_write", fsb_write_o, 1'b0);
    tick(); mid(); check("t6_rst_write_b", fsb_write_o, 1'b0);
    tick(); srstn_i = 1'b1;
    mid();
    check("t6_idle_ready", req_ready_o, 1'b1);
    check("t6_idle_valid", iss_valid_o, 1'b0);

    // Back-pressure from the FP unit
    tick(); iss_ready_i = 1'b0;
    set_pair(2'b11, '0, 3'b000, 1'b1, 5'd16, 8'h70, '0, 3'b000, 1'b0, 5'd17, 8'h71);
    tick(); req_valid_i = 2'b00;
    mid();
    check("t7_valid", iss_valid_o, 1'b1);
    check("t7_no_write", fsb_write_o, 1'b0);
    check("t7_not_ready", req_ready_o, 1'b0);
    tick(); tick(); mid(); check("t7_valid_held", iss_valid_o, 1'b1);
    tick(); iss_ready_i = 1'b1;
    mid(); check("t7_s0_rd", fsb_rdindex_o, 5'd16);
    tick(); mid();
    check("t7_s1_slot", iss_slot_o, 1'b1);
    check("t7_s1_no_write", fsb_write_o, 1'b0);
    check("t7_s1_ready", req_ready_o, 1'b1);

    // Streaming pairs with random back-pressure and occasional flush
    for (int n = 0; n < 80; n++) begin
      tick();
      set_pair(2'($urandom_range(1, 3)),
               15'($urandom), 3'b000, 1'($urandom), 5'($urandom), 8'($urandom),
               15'($urandom), 3'b000, 1'($urandom), 5'($urandom), 8'($urandom));
      iss_ready_i = 1'($urandom_range(0, 1));
      flush_i     = ($urandom_range(0, 15) == 0);
    end
    tick(); req_valid_i = 2'b00; iss_ready_i = 1'b1; flush_i = 1'b0;
    repeat (4) tick();
    mid();
    check("drain_ready", req_ready_o, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
